// File: rtl/pc_redirect_unit.sv
// Program-counter generation and fetch-redirect stage. It drives instruction-memory
// requests and steers fetch to taken-branch targets, then flushes younger instructions.
module pc_redirect_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            branch_valid_i,
    input  logic            is_branch_taken_i,
    input  logic [XLEN-1:0] branch_pc_i,
    input  logic [12:0]     branch_imm_i,
    input  logic            imem_gnt_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            redirect_o,
    output logic            flush_o,
    output logic            misaligned_o
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_GNT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);

    function automatic logic [XLEN-1:0] sext_imm(input logic [12:0] imm);
        return {{(XLEN-13){imm[12]}}, imm};
    endfunction

    state_t          state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] addr_r, addr_s;
    logic [2:0]      flush_cnt_r, flush_cnt_s;
    logic            pend_r, pend_s;
    logic [XLEN-1:0] target_s;
    logic            event_s, taken_s, misaligned_s;
    logic            req_s;
    logic [XLEN-1:0] addr_out_s;

    assign target_s     = branch_pc_i + sext_imm(branch_imm_i);
    // A branch resolving while we flush is itself being killed, so it is ignored.
    assign event_s      = branch_valid_i & is_branch_taken_i & (state_r != ST_FLUSH);
    assign taken_s      = event_s & ~target_s[1];
    assign misaligned_s = event_s & target_s[1];

    // Next-state, next-PC and memory-request generation.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        addr_s      = addr_r;
        flush_cnt_s = flush_cnt_r;
        pend_s      = pend_r;
        req_s       = 1'b0;
        addr_out_s  = pc_r;
        case (state_r)
            ST_BOOT: begin
                if (taken_s) begin
                    pc_s        = target_s;
                    flush_cnt_s = FLUSH_INIT;
                    state_s     = ST_FLUSH;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                req_s = ~stall_i;
                if (taken_s) begin
                    pc_s        = target_s;
                    flush_cnt_s = FLUSH_INIT;
                    state_s     = ST_FLUSH;
                end else if (stall_i) begin
                    state_s = ST_FETCH;
                end else if (imem_gnt_i) begin
                    pc_s = pc_r + PC_STEP;
                end else begin
                    addr_s  = pc_r;
                    state_s = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                // The outstanding request completes at its original address even if redirected.
                req_s      = 1'b1;
                addr_out_s = addr_r;
                if (imem_gnt_i) begin
                    if (taken_s || pend_r) begin
                        pc_s        = taken_s ? target_s : pc_r;
                        pend_s      = 1'b0;
                        flush_cnt_s = FLUSH_INIT;
                        state_s     = ST_FLUSH;
                    end else begin
                        pc_s    = addr_r + PC_STEP;
                        state_s = ST_FETCH;
                    end
                end else if (taken_s) begin
                    pc_s   = target_s;
                    pend_s = 1'b1;
                end else begin
                    pend_s = pend_r;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r <= 3'd1) begin
                    flush_cnt_s = 3'd0;
                    state_s     = ST_FETCH;
                end else begin
                    flush_cnt_s = flush_cnt_r - 3'd1;
                    state_s     = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase
    end

    // State, PC, held request address and flush counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_BOOT;
            pc_r        <= RESET_PC;
            addr_r      <= RESET_PC;
            flush_cnt_r <= 3'd0;
            pend_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            addr_r      <= addr_s;
            flush_cnt_r <= flush_cnt_s;
            pend_r      <= pend_s;
        end
    end

    assign imem_req_o   = req_s;
    assign imem_addr_o  = addr_out_s;
    assign pc_o         = pc_r;
    assign redirect_o   = taken_s;
    assign flush_o      = (state_r == ST_FLUSH);
    assign misaligned_o = misaligned_s;

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter generation and fetch-redirect stage directly downstream of the branch unit.
- Consumes the branch-taken decision plus the resolving branch's PC and immediate.
- Computes the branch target, steers the instruction-memory request address, and flushes the younger in-flight instructions for a fixed number of cycles.
- Sequential: PC register, fetch FSM with request/grant handshake, and flush counter.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (legal range 1..7)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-low
stall_i  input  1  pipeline stall; blocks issue of a new fetch request
branch_valid_i  input  1  a conditional branch resolves this cycle
is_branch_taken_i  input  1  branch condition satisfied; qualified by branch_valid_i
branch_pc_i  input  XLEN  PC of the resolving branch
branch_imm_i  input  13  B-type immediate; bit0 always 0
imem_gnt_i  input  1  instruction memory accepts the current request
imem_req_o  output  1  fetch request
imem_addr_o  output  XLEN  fetch address; stable while imem_req_o=1 and no grant
pc_o  output  XLEN  next PC to fetch (pc_q)
redirect_o  output  1  one-cycle pulse when a taken branch updates pc_q
flush_o  output  1  kill the IF/ID instructions
misaligned_o  output  1  one-cycle pulse when a taken target has bit1 set

Behaviour:
- Reset (rst_i=0, async): pc_q=RESET_PC, addr_q=RESET_PC, state=BOOT, flush_cnt=0. All outputs 0, except pc_o=imem_addr_o=RESET_PC.
- Target computation: target = branch_pc_i + sign_extend(branch_imm_i), modulo 2^XLEN. Sequential increment pc_q+4 also wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0).
- Taken event: branch_valid_i & is_branch_taken_i & state!=FLUSH.
  - branch_valid_i is ignored in FLUSH, because the instruction is being killed.
- Misaligned taken event (target[1]=1): misaligned_o=1 for one cycle, no redirect, no flush, and pc_q continues sequentially.
- Priority, highest first: reset, taken event, stall_i, sequential fetch.

FSM states:
- BOOT: imem_req_o=0. Moves to FETCH on the next clock after reset release.
- FETCH: imem_req_o = ~stall_i. imem_addr_o = pc_q, combinationally.
  - req & gnt: pc_q <= pc_q+4; stay.
  - req & !gnt: addr_q <= pc_q; go to WAIT_GNT.
  - stall_i=1: no request; pc_q holds.
- WAIT_GNT: imem_req_o=1 regardless of stall_i. imem_addr_o=addr_q, held constant.
  - gnt: pc_q <= addr_q+4 (unless a redirect is pending); go to FETCH, or FLUSH if redirect_pend=1.
  - A taken event here updates pc_q <= target and sets redirect_pend. The outstanding request still completes at its original address.
- FLUSH: imem_req_o=0, flush_o=1, flush_cnt decrements each cycle.
  - At flush_cnt==1, go to FETCH; the first fetch uses the redirected pc_q.
- Taken event in FETCH or BOOT:
  - pc_q <= target, redirect_o=1 (same cycle as the event, combinational pulse), flush_cnt <= FLUSH_CYCLES, state <= FLUSH.
  - Any grant received in that same cycle is discarded: pc_q takes the target, not pc_q+4.
- Taken event in WAIT_GNT:
  - redirect_o pulses in the event cycle.
  - flush_o asserts from the grant cycle's next edge for FLUSH_CYCLES cycles.
- Latency: taken event to first redirected request = FLUSH_CYCLES+1 cycles when starting from FETCH.
- Simultaneous stall_i and taken event: the redirect wins, and stall only delays the first fetch after FLUSH.
- Reset mid-WAIT_GNT: the request drops immediately; the memory side must tolerate an abandoned request.

Test Plan:
- Reset release, gnt=1 always, no stall: imem_addr_o sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles starting one cycle after BOOT.
- Taken branch with branch_pc_i=0x100, imm=-8 (13'h1FF8) in FETCH: redirect_o pulse, flush_o high 2 cycles, imem_req_o low 2 cycles, next request addr 0xF8.
- gnt held 0 for 3 cycles at addr 0x20 while stall_i toggles: imem_req_o stays 1 and imem_addr_o stays 0x20. After grant, next addr 0x24.
- Taken branch to 0x400 during WAIT_GNT at 0x20: req holds 0x20 until gnt, then flush 2 cycles, then fetch 0x400.
- Taken branch with target 0x102 (bit1 set): misaligned_o pulse, redirect_o=0, flush_o=0, sequential fetch continues. A branch_valid_i during FLUSH is ignored, with pc_q unchanged.
- RESET_PC=0xFFFF_FFFC: first fetch 0xFFFF_FFFC, second fetch 0x0000_0000 (wrap). Asserting rst_i low mid-WAIT_GNT gives imem_req_o=0 asynchronously.
